// File: rtl/sp_mem_arbiter_if.sv
// Bus bundle between the scratchpad/core requesters, the arbiter and the word RAM.
// slave: the arbiter side; master: the requester/RAM side that drives the requests.
interface sp_mem_arbiter_if #(
  parameter int WORD_W       = 32,
  parameter int BITS_PER_ROW = 64,
  parameter int ROW_S_W      = 2
);
  logic                    sLoad;
  logic                    sStore;
  logic [WORD_W-1:0]       load_addr;
  logic [WORD_W-1:0]       store_addr;
  logic [BITS_PER_ROW-1:0] store_data;
  logic [BITS_PER_ROW-1:0] load_data;
  logic                    sLoad_hit;
  logic                    sStore_hit;
  logic [ROW_S_W-1:0]      sLoad_row;

  logic                    core_ren;
  logic                    core_wen;
  logic [WORD_W-1:0]       core_addr;
  logic [WORD_W-1:0]       core_wdata;
  logic [WORD_W-1:0]       core_rdata;
  logic                    core_ready;

  logic                    ram_ren;
  logic                    ram_wen;
  logic [WORD_W-1:0]       ram_addr;
  logic [WORD_W-1:0]       ram_wdata;
  logic [WORD_W-1:0]       ram_rdata;
  logic                    ram_ready;

  modport slave (
    input  sLoad, sStore, load_addr, store_addr, store_data,
    input  core_ren, core_wen, core_addr, core_wdata,
    input  ram_rdata, ram_ready,
    output load_data, sLoad_hit, sStore_hit, sLoad_row,
    output core_rdata, core_ready,
    output ram_ren, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output sLoad, sStore, load_addr, store_addr, store_data,
    output core_ren, core_wen, core_addr, core_wdata,
    output ram_rdata, ram_ready,
    input  load_data, sLoad_hit, sStore_hit, sLoad_row,
    input  core_rdata, core_ready,
    input  ram_ren, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sp_mem_arbiter.sv
// Shares one word-wide RAM port between the host core data port and scratchpad
// row traffic. Rows move as two little-endian word beats; load rows are
// reassembled and tagged with a wrapping destination row index.
//
// state | meaning
// IDLE  | no RAM access; choose next requester (round-robin core vs scratchpad)
// CORE  | one core word beat
// LD0   | row load, low word at aligned base
// LD1   | row load, high word at base+4; load hit on completion
// ST0   | row store, low word at aligned base
// ST1   | row store, high word at base+4; store hit on completion
module sp_mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int BITS_PER_ROW = 64,
  parameter int ROW_S_W      = 2
) (
  input logic             CLK,
  input logic             nRST,
  sp_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CORE, LD0, LD1, ST0, ST1} state_t;
  typedef enum logic {GRANT_SP, GRANT_CORE} grant_t;

  state_t state, state_nxt;
  grant_t last_grant;

  logic [ROW_S_W-1:0]      row_cnt;
  logic [WORD_W-1:0]       first_beat;

  logic                    core_req, sp_req, grant_core;
  logic [WORD_W-1:0]       ld_base, st_base;

  logic                    ram_ren_c, ram_wen_c;
  logic [WORD_W-1:0]       ram_addr_c, ram_wdata_c, core_rdata_c;
  logic                    core_ready_c, ld_hit_c, st_hit_c;
  logic [BITS_PER_ROW-1:0] load_data_c;
  logic [ROW_S_W-1:0]      ld_row_c;

  assign core_req   = bus.core_ren | bus.core_wen;
  assign sp_req     = bus.sLoad | bus.sStore;
  // core wins when alone, or when both wait and the scratchpad went last
  assign grant_core = core_req & (~sp_req | (last_grant == GRANT_SP));
  assign ld_base    = {bus.load_addr[WORD_W-1:3], 3'b000};
  assign st_base    = {bus.store_addr[WORD_W-1:3], 3'b000};

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // grant history, first load beat and destination row counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= GRANT_SP;
      first_beat <= '0;
      row_cnt    <= '0;
    end else begin
      if (state == IDLE && (core_req || sp_req))
        last_grant <= grant_core ? GRANT_CORE : GRANT_SP;
      if (state == LD0 && bus.ram_ready)
        first_beat <= bus.ram_rdata;
      if (ld_hit_c)
        row_cnt <= row_cnt + ROW_S_W'(1);
    end
  end

  // next state and all bus outputs; everything idles at zero
  always_comb begin
    state_nxt    = state;
    ram_ren_c    = 1'b0;
    ram_wen_c    = 1'b0;
    ram_addr_c   = '0;
    ram_wdata_c  = '0;
    core_ready_c = 1'b0;
    core_rdata_c = '0;
    ld_hit_c     = 1'b0;
    st_hit_c     = 1'b0;
    load_data_c  = '0;
    ld_row_c     = '0;
    case (state)
      IDLE: begin
        if (grant_core)       state_nxt = CORE;
        else if (bus.sLoad)   state_nxt = LD0;
        else if (bus.sStore)  state_nxt = ST0;
      end
      CORE: begin
        ram_wen_c    = bus.core_wen;
        ram_ren_c    = bus.core_ren & ~bus.core_wen;
        ram_addr_c   = bus.core_addr;
        ram_wdata_c  = bus.core_wdata;
        core_ready_c = bus.ram_ready;
        if (bus.ram_ready) begin
          core_rdata_c = bus.ram_rdata;
          state_nxt    = IDLE;
        end
      end
      LD0: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = ld_base;
        if (bus.ram_ready) state_nxt = LD1;
      end
      LD1: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = ld_base + WORD_W'(4);
        if (bus.ram_ready) begin
          ld_hit_c    = 1'b1;
          load_data_c = {bus.ram_rdata, first_beat};
          ld_row_c    = row_cnt;
          state_nxt   = IDLE;
        end
      end
      ST0: begin
        ram_wen_c   = 1'b1;
        ram_addr_c  = st_base;
        ram_wdata_c = bus.store_data[WORD_W-1:0];
        if (bus.ram_ready) state_nxt = ST1;
      end
      ST1: begin
        ram_wen_c   = 1'b1;
        ram_addr_c  = st_base + WORD_W'(4);
        ram_wdata_c = bus.store_data[BITS_PER_ROW-1:WORD_W];
        if (bus.ram_ready) begin
          st_hit_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ram_ren    = ram_ren_c;
  assign bus.ram_wen    = ram_wen_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;
  assign bus.core_ready = core_ready_c;
  assign bus.core_rdata = core_rdata_c;
  assign bus.sLoad_hit  = ld_hit_c;
  assign bus.sStore_hit = st_hit_c;
  assign bus.load_data  = load_data_c;
  assign bus.sLoad_row  = ld_row_c;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: directed scenarios followed by randomized traffic
// from three requesters against a transaction-level model of the RAM and rows.
`timescale 1ns/1ps
module tb_sp_mem_arbiter;
  localparam int WORD_W       = 32;
  localparam int BITS_PER_ROW = 64;
  localparam int ROW_S_W      = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   row_m = 0;
  logic [63:0] wlog[$];
  int   seq[$];

  sp_mem_arbiter_if #(.WORD_W(WORD_W), .BITS_PER_ROW(BITS_PER_ROW), .ROW_S_W(ROW_S_W)) bus();

  sp_mem_arbiter #(.WORD_W(WORD_W), .BITS_PER_ROW(BITS_PER_ROW), .ROW_S_W(ROW_S_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // RAM read contents: two fixed words, everything else a bijection of the address
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hAAAA_0001;
    if (a == 32'h0000_0104) return 32'hBBBB_0002;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.ram_rdata = rd_val(bus.ram_addr);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // sample point: log completed write beats and check per-cycle invariants
  task automatic nedge();
    @(negedge CLK);
    if (nRST) begin
      if (bus.ram_wen && bus.ram_ready) wlog.push_back({bus.ram_addr, bus.ram_wdata});
      check("ren_wen_excl", 64'(bus.ram_ren & bus.ram_wen), 0);
      check("one_strobe", 64'((int'(bus.sLoad_hit) + int'(bus.sStore_hit) + int'(bus.core_ready)) > 1), 0);
      check("ld_data_idle", bus.sLoad_hit ? 64'd0 : bus.load_data, 0);
      check("rdata_idle", bus.core_ready ? 64'd0 : 64'(bus.core_rdata), 0);
    end
  endtask

  task automatic drop_all();
    bus.sLoad = 0; bus.sStore = 0; bus.core_ren = 0; bus.core_wen = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    drop_all();
    bus.ram_ready = 0;
    row_m = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
    tick();
  endtask

  task automatic do_load(input logic [31:0] addr, output int lat);
    logic [31:0] base;
    bit got;
    base = addr & 32'hFFFF_FFF8;
    bus.sLoad = 1; bus.load_addr = addr;
    lat = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      nedge();
      lat++;
      if (bus.sLoad_hit) begin
        got = 1;
        check("ld_data", bus.load_data, {rd_val(base + 32'd4), rd_val(base)});
        check("ld_row", 64'(bus.sLoad_row), 64'(row_m));
        row_m = (row_m + 1) % 4;
      end
      tick();
    end
    if (!got) check("ld_timeout", 64'(lat), 0);
    bus.sLoad = 0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [63:0] data, output int lat);
    logic [31:0] base;
    bit got;
    base = addr & 32'hFFFF_FFF8;
    wlog.delete();
    bus.sStore = 1; bus.store_addr = addr; bus.store_data = data;
    lat = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      nedge();
      lat++;
      if (bus.sStore_hit) begin
        got = 1;
        check("st_nbeats", 64'(wlog.size()), 2);
        if (wlog.size() == 2) begin
          check("st_beat_lo", wlog[0], {base, data[31:0]});
          check("st_beat_hi", wlog[1], {base + 32'd4, data[63:32]});
        end
      end
      tick();
    end
    if (!got) check("st_timeout", 64'(lat), 0);
    bus.sStore = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp4[4];
    bit drop_ld, drop_st;
    bit c_act, c_wr, c_rd_too, l_act, s_act;
    logic [31:0] c_addr, c_wdata, l_addr, s_addr;
    logic [63:0] s_data;
    int c_age, l_age, s_age;
    bit core_mark, sp_mark;

    drop_all();
    bus.load_addr = 0; bus.store_addr = 0; bus.store_data = 0;
    bus.core_addr = 0; bus.core_wdata = 0; bus.ram_ready = 0;

    // reset: outputs zero even with requests and ram_ready pending
    bus.sLoad = 1; bus.core_ren = 1; bus.ram_ready = 1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_ram_ren", 64'(bus.ram_ren), 0);
    check("rst_ram_wen", 64'(bus.ram_wen), 0);
    check("rst_ram_addr", 64'(bus.ram_addr), 0);
    check("rst_ram_wdata", 64'(bus.ram_wdata), 0);
    check("rst_core_ready", 64'(bus.core_ready), 0);
    check("rst_core_rdata", 64'(bus.core_rdata), 0);
    check("rst_ld_hit", 64'(bus.sLoad_hit), 0);
    check("rst_st_hit", 64'(bus.sStore_hit), 0);
    check("rst_load_data", bus.load_data, 0);
    check("rst_ld_row", 64'(bus.sLoad_row), 0);
    drop_all();
    bus.ram_ready = 0;
    nRST = 1;
    tick();

    // single row load, zero-wait RAM
    bus.ram_ready = 1;
    do_load(32'h0000_0100, lat);
    check("t1_lat", 64'(lat), 3);

    // five back-to-back loads from a fresh counter: rows 0,1,2,3,0
    do_reset();
    bus.ram_ready = 1;
    for (int i = 0; i < 5; i++) begin
      do_load(32'h0000_0400 + 32'(i * 8) + 32'($urandom_range(7)), lat);
      check("t2_lat", 64'(lat), 3);
    end

    // unaligned row store, low word first
    do_store(32'h0000_0207, 64'h1111_2222_3333_4444, lat);
    check("t3_lat", 64'(lat), 3);

    // all three requesting from reset: core, load, core, store
    nRST = 0;
    bus.core_ren = 1; bus.core_addr = 32'h0000_0500;
    bus.sLoad = 1;    bus.load_addr = 32'h0000_0600;
    bus.sStore = 1;   bus.store_addr = 32'h0000_0700; bus.store_data = 64'hCAFE_F00D_1234_5678;
    bus.ram_ready = 1;
    row_m = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
    seq.delete();
    for (int i = 1; i <= 12; i++) begin
      drop_ld = 0; drop_st = 0;
      nedge();
      if (bus.core_ready) begin
        seq.push_back(100 + i);
        check("t4_core_rd", 64'(bus.core_rdata), 64'(rd_val(32'h0000_0500)));
      end
      if (bus.sLoad_hit) begin
        seq.push_back(200 + i);
        check("t4_ld_data", bus.load_data, {rd_val(32'h0000_0604), rd_val(32'h0000_0600)});
        check("t4_ld_row", 64'(bus.sLoad_row), 64'(row_m));
        row_m = (row_m + 1) % 4;
        drop_ld = 1;
      end
      if (bus.sStore_hit) begin
        seq.push_back(300 + i);
        drop_st = 1;
      end
      tick();
      if (drop_ld) bus.sLoad = 0;
      if (drop_st) bus.sStore = 0;
    end
    exp4[0] = 101; exp4[1] = 204; exp4[2] = 106; exp4[3] = 309;
    check("t4_nstrobes", 64'(seq.size() >= 4), 1);
    for (int k = 0; k < 4; k++)
      if (k < seq.size()) check("t4_order", 64'(seq[k]), 64'(exp4[k]));

    // wait states in LD1 with a core write arriving mid-row
    do_reset();
    bus.sLoad = 1; bus.load_addr = 32'h0000_0100; bus.ram_ready = 1;
    nedge();
    tick();
    nedge();
    check("t5_ld0_addr", 64'(bus.ram_addr), 64'h100);
    tick();
    bus.ram_ready = 0;
    bus.core_wen = 1; bus.core_addr = 32'h0000_3000; bus.core_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      nedge();
      check("t5_wait_ren", 64'(bus.ram_ren), 1);
      check("t5_wait_wen", 64'(bus.ram_wen), 0);
      check("t5_wait_addr", 64'(bus.ram_addr), 64'h104);
      check("t5_wait_hit", 64'(bus.sLoad_hit), 0);
      check("t5_wait_cready", 64'(bus.core_ready), 0);
      tick();
    end
    bus.ram_ready = 1;
    nedge();
    check("t5_hit", 64'(bus.sLoad_hit), 1);
    check("t5_data", bus.load_data, 64'hBBBB_0002_AAAA_0001);
    check("t5_row", 64'(bus.sLoad_row), 0);
    row_m = 1;
    tick();
    bus.sLoad = 0;
    nedge();
    check("t5_idle_wen", 64'(bus.ram_wen), 0);
    check("t5_idle_cready", 64'(bus.core_ready), 0);
    tick();
    nedge();
    check("t5_core_beat", {bus.ram_addr, bus.ram_wdata}, 64'h0000_3000_DEAD_BEEF);
    check("t5_core_wen", 64'(bus.ram_wen), 1);
    check("t5_core_ready", 64'(bus.core_ready), 1);
    tick();
    bus.core_wen = 0;

    // reset in the middle of ST1
    bus.sStore = 1; bus.store_addr = 32'h0000_0300; bus.store_data = 64'h0102_0304_0506_0708;
    nedge();
    tick();
    nedge();
    check("t6_st0_addr", 64'(bus.ram_addr), 64'h300);
    tick();
    bus.ram_ready = 0;
    nedge();
    check("t6_st1_wen", 64'(bus.ram_wen), 1);
    check("t6_st1_addr", 64'(bus.ram_addr), 64'h304);
    nRST = 0;
    #1;
    check("t6_rst_wen", 64'(bus.ram_wen), 0);
    check("t6_rst_hit", 64'(bus.sStore_hit), 0);
    check("t6_rst_addr", 64'(bus.ram_addr), 0);
    bus.sStore = 0;
    bus.ram_ready = 1;
    row_m = 0;
    @(negedge CLK);
    check("t6_held_hit", 64'(bus.sStore_hit), 0);
    nRST = 1;
    tick();
    do_load(32'h0000_0100, lat);
    check("t6_post_lat", 64'(lat), 3);

    // randomized traffic from core, row-load and row-store requesters
    do_reset();
    wlog.delete();
    c_act = 0; l_act = 0; s_act = 0; c_wr = 0; c_rd_too = 0;
    c_addr = 0; c_wdata = 0; l_addr = 0; s_addr = 0; s_data = 0;
    c_age = 0; l_age = 0; s_age = 0;
    core_mark = 0; sp_mark = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.core_ren   = c_act & (~c_wr | c_rd_too);
      bus.core_wen   = c_act & c_wr;
      bus.core_addr  = c_addr;
      bus.core_wdata = c_wdata;
      bus.sLoad      = l_act;
      bus.load_addr  = l_addr;
      bus.sStore     = s_act;
      bus.store_addr = s_addr;
      bus.store_data = s_data;
      bus.ram_ready  = ($urandom_range(9) < 7);
      nedge();

      if (bus.core_ready) begin
        if (!c_act) check("core_spurious", 64'(bus.core_ready), 0);
        else begin
          if (c_wr) check("core_wr_beat", {bus.ram_addr, bus.ram_wdata}, {c_addr, c_wdata});
          else      check("core_rd", 64'(bus.core_rdata), 64'(rd_val(c_addr)));
          check("rr_core_twice", 64'(sp_mark), 0);
          sp_mark = l_act | s_act;
          core_mark = 0;
          c_act = 0;
        end
      end
      if (bus.sLoad_hit) begin
        if (!l_act) check("ld_spurious", 64'(bus.sLoad_hit), 0);
        else begin
          check("rnd_ld_data", bus.load_data,
                {rd_val((l_addr & 32'hFFFF_FFF8) + 32'd4), rd_val(l_addr & 32'hFFFF_FFF8)});
          check("rnd_ld_row", 64'(bus.sLoad_row), 64'(row_m));
          row_m = (row_m + 1) % 4;
          check("rr_sp_twice", 64'(core_mark), 0);
          core_mark = c_act;
          sp_mark = 0;
          l_act = 0;
        end
      end
      if (bus.sStore_hit) begin
        if (!s_act) check("st_spurious", 64'(bus.sStore_hit), 0);
        else begin
          check("rnd_st_nbeats", 64'(wlog.size() >= 2), 1);
          if (wlog.size() >= 2) begin
            check("rnd_st_lo", wlog[wlog.size()-2], {s_addr & 32'hFFFF_FFF8, s_data[31:0]});
            check("rnd_st_hi", wlog[wlog.size()-1], {(s_addr & 32'hFFFF_FFF8) + 32'd4, s_data[63:32]});
          end
          check("rr_sp_twice", 64'(core_mark), 0);
          core_mark = c_act;
          sp_mark = 0;
          s_act = 0;
        end
      end

      if (c_act) begin
        c_age++;
        if (c_age > 200) begin check("core_wait", 64'(c_age), 200); c_act = 0; end
      end
      if (l_act) begin
        l_age++;
        if (l_age > 200) begin check("ld_wait", 64'(l_age), 200); l_act = 0; end
      end
      if (s_act) begin
        s_age++;
        if (s_age > 200) begin check("st_wait", 64'(s_age), 200); s_act = 0; end
      end

      if (!c_act && $urandom_range(2) == 0) begin
        c_act = 1; c_age = 0;
        c_wr = 1'($urandom_range(1));
        c_rd_too = 1'($urandom_range(1));
        c_addr = $urandom; c_wdata = $urandom;
      end
      if (!l_act && $urandom_range(2) == 0) begin
        l_act = 1; l_age = 0; l_addr = $urandom;
      end
      if (!s_act && $urandom_range(2) == 0) begin
        s_act = 1; s_age = 0; s_addr = $urandom; s_data = {$urandom, $urandom};
      end
      tick();
    end
    drop_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
